// File: rtl/seq_pkg.sv
// Shared definitions for the Y86-64 SEQ processor: instruction codes,
// status encodings and the controller state type.
package seq_pkg;

  localparam logic [3:0] ICODE_HALT  = 4'h0;
  localparam logic [3:0] ICODE_NOP   = 4'h1;
  localparam logic [3:0] ICODE_CMOV  = 4'h2;
  localparam logic [3:0] ICODE_IRMOV = 4'h3;
  localparam logic [3:0] ICODE_RMMOV = 4'h4;
  localparam logic [3:0] ICODE_MRMOV = 4'h5;
  localparam logic [3:0] ICODE_OPQ   = 4'h6;
  localparam logic [3:0] ICODE_JXX   = 4'h7;
  localparam logic [3:0] ICODE_CALL  = 4'h8;
  localparam logic [3:0] ICODE_RET   = 4'h9;
  localparam logic [3:0] ICODE_PUSH  = 4'hA;
  localparam logic [3:0] ICODE_POP   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_STOP      = 3'd7
  } state_t;

  // Instructions that touch data memory (loads, stores, stack ops).
  function automatic logic uses_dmem(input logic [3:0] icode);
    return (icode == ICODE_RMMOV) || (icode == ICODE_MRMOV) ||
           (icode == ICODE_CALL)  || (icode == ICODE_RET)   ||
           (icode == ICODE_PUSH)  || (icode == ICODE_POP);
  endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC selection, shared with the PIPE predictor.
module seq_next_pc
  import seq_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] new_pc
);

  // Calls and taken jumps go to valC, ret to the popped address, else fall through.
  always_comb begin
    new_pc = valP;
    case (icode)
      ICODE_CALL: new_pc = valC;
      ICODE_JXX:  new_pc = cnd ? valC : valP;
      ICODE_RET:  new_pc = valM;
      default:    new_pc = valP;
    endcase
  end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle SEQ controller: owns pc and stat, steps each instruction
// through the stages one enable per cycle, and handshakes with data memory.
//
// Memory handshake: mem_req is high for every MEMORY cycle; the access
// completes in the first cycle mem_ready is sampled high at the rising edge,
// with valM/dmem_error qualified by mem_ready in that same cycle. There is no
// back-pressure from the controller side; an abandoned request (reset) simply
// drops mem_req.
module seq_controller
  import seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        hlt_in,
  input  logic        imem_error,
  input  logic        instr_valid,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  input  logic        cnd,
  input  logic        dmem_error,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic [63:0] pc,
  output logic [1:0]  stat,
  output logic        busy,
  output logic [31:0] instr_count,
  output state_t      state
);

  localparam int CLOG_W = $clog2(MEM_TIMEOUT + 1);
  localparam int WAIT_W = (CLOG_W > 4) ? CLOG_W : 4;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                cnd_q;
  logic [63:0]         valm_q;
  logic [63:0]         new_pc;
  logic                fetch_fault;
  logic                mem_timeout;

  assign fetch_fault = imem_error || !instr_valid || hlt_in;
  assign mem_timeout = (wait_cnt == WAIT_LIMIT);

  seq_next_pc u_next_pc (
    .icode  (icode),
    .cnd    (cnd_q),
    .valC   (valC),
    .valP   (valP),
    .valM   (valm_q),
    .new_pc (new_pc)
  );

  // Next-state selection for the instruction sequencer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = S_FETCH;
      S_FETCH:     state_next = fetch_fault ? S_STOP : S_DECODE;
      S_DECODE:    state_next = S_EXECUTE;
      S_EXECUTE:   state_next = uses_dmem(icode) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (mem_ready)        state_next = dmem_error ? S_STOP : S_WRITEBACK;
        else if (mem_timeout) state_next = S_STOP;
      end
      S_WRITEBACK: state_next = S_PCUPD;
      S_PCUPD:     state_next = S_FETCH;
      S_STOP:      state_next = S_STOP;
      default:     state_next = S_IDLE;
    endcase
  end

  // State register, registered Moore outputs and architectural state updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      f_en        <= 1'b0;
      d_en        <= 1'b0;
      e_en        <= 1'b0;
      m_en        <= 1'b0;
      w_en        <= 1'b0;
      mem_req     <= 1'b0;
      busy        <= 1'b0;
      pc          <= RESET_PC;
      stat        <= STAT_AOK;
      instr_count <= 32'd0;
      wait_cnt    <= '0;
      cnd_q       <= 1'b0;
      valm_q      <= 64'd0;
    end else begin
      state   <= state_next;
      f_en    <= (state_next == S_FETCH);
      d_en    <= (state_next == S_DECODE);
      e_en    <= (state_next == S_EXECUTE);
      m_en    <= (state_next == S_MEMORY);
      w_en    <= (state_next == S_WRITEBACK);
      mem_req <= (state_next == S_MEMORY);
      busy    <= (state_next != S_IDLE) && (state_next != S_STOP);

      case (state)
        S_FETCH: begin
          if (imem_error)        stat <= STAT_ADR;
          else if (!instr_valid) stat <= STAT_INS;
          else if (hlt_in)       stat <= STAT_HLT;
        end
        S_EXECUTE: begin
          cnd_q    <= cnd;
          wait_cnt <= '0;
        end
        S_MEMORY: begin
          if (mem_ready) begin
            if (dmem_error) stat   <= STAT_ADR;
            else            valm_q <= valM;
          end else if (mem_timeout) begin
            stat <= STAT_ADR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_PCUPD: begin
          pc          <= new_pc;
          instr_count <= instr_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_controller.md
# seq_controller

Multi-cycle sequencer for the Y86-64 SEQ datapath. It owns the program counter and the processor status register. It steps each instruction through fetch, decode, execute, memory, write-back and PC-update phases by pulsing one stage enable per cycle. It handshakes with the data-memory port, which has variable latency, and stops the machine on halt, invalid instruction or address error.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- MEM_TIMEOUT, 15, maximum MEMORY-state wait cycles for mem_ready before an address error is raised.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins execution from IDLE.
- icode  in  4  instruction code from fetch; valid in FETCH cycle, held by datapath until next FETCH.
- hlt_in, imem_error, instr_valid  in  1 each  fetch status; valid in FETCH cycle.
- valP, valC  in  64 each  fetch results.
- valM  in  64  memory read data; valid with mem_ready.
- cnd  in  1  branch condition from execute; valid in EXECUTE cycle.
- dmem_error  in  1  data-memory fault; valid with mem_ready.
- mem_ready  in  1  data-memory completion.
- mem_req  out  1  data-memory access request.
- f_en, d_en, e_en, m_en, w_en  out  1 each  one-hot stage enables.
- pc  out  64  current PC.
- stat  out  2  AOK=0, HLT=1, ADR=2, INS=3.
- busy  out  1  high in every state except IDLE and STOP.
- instr_count  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- IDLE: on start=1, go to FETCH; otherwise remain in IDLE.
- FETCH (f_en=1): fault checks in priority order:
  - imem_error → stat=ADR.
  - !instr_valid → stat=INS.
  - hlt_in → stat=HLT.
  - Any of the three → go to STOP; otherwise go to DECODE.
- DECODE (d_en=1): go to EXECUTE.
- EXECUTE (e_en=1):
  - Latch cnd.
  - icode ∈ {4,5,8,9,A,B} → MEMORY.
  - Otherwise → WRITEBACK.
- MEMORY (m_en=1, mem_req=1):
  - Wait for mem_ready.
  - On mem_ready with dmem_error → stat=ADR, go to STOP.
  - On mem_ready without error → latch valM, go to WRITEBACK.
  - Wait counter reaching MEM_TIMEOUT without mem_ready → stat=ADR, go to STOP.
- WRITEBACK (w_en=1): go to PCUPD.
- PCUPD: compute the next PC, increment instr_count, go to FETCH. Next-PC selection:
  - icode 8 → valC.
  - icode 7 → valC if latched cnd else valP.
  - icode 9 → latched valM.
  - All other icodes → valP.
- STOP: terminal. start is ignored, all enables are 0, pc and stat are frozen. Only reset leaves STOP.
- Arithmetic:
  - pc uses 64-bit unsigned values; no bounds checking (fetch reports imem_error).
  - instr_count wraps modulo 2^32.
  - Wait counter is 4 bits wide minimum, or ceil(log2(MEM_TIMEOUT+1)) bits; cleared on MEMORY entry.
- A faulting instruction does not retire: pc stays at the faulting instruction and instr_count is not incremented.

## Timing
- Reset values (asynchronous): state=IDLE, pc=RESET_PC, stat=AOK, all enables and mem_req=0, busy=0, instr_count=0, wait counter=0.
- Outputs are registered (Moore, decoded from state). The stage enable and mem_req are high for exactly the cycles the FSM spends in that state.
- Latency per instruction, FETCH to next FETCH:
  - Non-memory instruction: 5 cycles.
  - Memory instruction: 6+w cycles, where w is the number of cycles mem_ready stays low after MEMORY entry.
  - mem_ready already high on the first MEMORY cycle gives w=0.
- pc updates on the clock edge that leaves PCUPD, so the new value is visible in the following FETCH cycle.
- stat updates on the edge entering STOP.
- Timeout boundary: MEMORY lasts at most MEM_TIMEOUT+1 cycles. mem_ready arriving in the final cycle counts as success.
- Reset mid-instruction: asynchronous. mem_req deasserts immediately with no handshake completion; the memory side must tolerate an abandoned request.

## Structure
- Shared package seq_pkg holds:
  - icode constants: HALT, NOP, CMOV, IRMOV, RMMOV, MRMOV, OPQ, JXX, CALL, RET, PUSH, POP.
  - stat encodings.
  - Controller state enum.
  - fetch and the future decode/execute stages import the same package.
- One sub-module: seq_next_pc. It is purely combinational: icode, cnd, valC, valP, valM → new_pc. It is reused by the planned PIPE predictor.

## Test plan
- Reset, then start, with program nop (0x10) at 0: enables F,D,E,W,PCUPD over 5 cycles; pc=1; instr_count=1; stat=AOK.
- call at PC=0 with valC=0x100 and mem_ready after 3 wait cycles: MEMORY lasts 4 cycles, mem_req is high throughout, and pc=0x100 on the next FETCH.
- jXX with valC=0x40 and valP=9: cnd=1 gives pc=0x40; cnd=0 gives pc=9.
- halt at PC=5: stat=HLT, STOP entered after the FETCH cycle, pc stays 5, busy=0, and a later start has no effect.
- invalid icode (0xC0): stat=INS. imem_error together with !instr_valid: stat=ADR (priority).
- mrmovq with mem_ready never asserted and MEM_TIMEOUT=15: stat=ADR after 16 MEMORY cycles. Separately, rst_n low during MEMORY clears mem_req, pc and stat within the same cycle.
